// File: rtl/approx_pkg.sv
// Shared defaults and the effective-depth rule for the approximate adder.
// Pure definitions: no logic, no latency.
// No flow control here; users handle their own handshakes.
package approx_pkg;

  localparam int N_DEF     = 16;
  localparam int P_MAX_DEF = 8;
  localparam int KW_DEF    = $clog2(P_MAX_DEF + 1);

  // Exact mode forces depth 0; otherwise the request is clamped to p_max.
  function automatic int eff_depth(input int k, input logic mode_exact, input int p_max);
    if (mode_exact) return 0;
    return (k > p_max) ? p_max : k;
  endfunction

endpackage

// File: rtl/approx_adder_pipe_lower.sv
// Lower approximate part: OR bits below ke-1, XOR at ke-1, carry from ke-1.
// Combinational, zero latency.
// No flow control; bits at and above ke are driven to 0.
module approx_lower_unit
  import approx_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int P_MAX = P_MAX_DEF,
  localparam int KL   = $clog2(P_MAX + 1)
) (
  input  logic [N-1:0]     x,
  input  logic [N-1:0]     y,
  input  logic [KL-1:0]    ke,
  output logic [P_MAX-1:0] lo,
  output logic             carry
);

  // Per-bit approximate sum; the top approximate bit also generates the carry.
  always_comb begin
    lo    = '0;
    carry = 1'b0;
    for (int i = 0; i < P_MAX; i++) begin
      if (i + 1 < int'(ke)) begin
        lo[i] = x[i] | y[i];
      end else if (i + 1 == int'(ke)) begin
        lo[i] = (x[i] & y[i]) ? 1'b0 : (x[i] | y[i]);
        carry = x[i] & y[i];
      end
    end
  end

endmodule

// File: rtl/approx_adder_pipe.sv
// Two-stage approximate adder: S1 holds lower result/carry/operands, S2 holds sum/err.
// Latency 2 cycles from accept to out_valid; one beat per cycle when out_ready=1.
// Skid-free backpressure: in_ready = S1 empty or S2 loading; outputs hold while stalled.
module approx_adder_pipe
  import approx_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int P_MAX = P_MAX_DEF,
  parameter int KW    = $clog2(P_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  x,
  input  logic [N-1:0]  y,
  input  logic [KW-1:0] k,
  input  logic          mode_exact,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N:0]    sum,
  output logic          err_flag,
  output logic [15:0]   err_count,
  input  logic          clr_count
);

  localparam int KL = $clog2(P_MAX + 1);

  logic [KL-1:0]    ke_in;
  logic [P_MAX-1:0] lo_in;
  logic             carry_in;

  logic             s1_vld;
  logic [KL-1:0]    s1_ke;
  logic [P_MAX-1:0] s1_lo;
  logic             s1_carry;
  logic [N-1:0]     s1_x;
  logic [N-1:0]     s1_y;

  logic             s2_load;
  logic             s1_load;
  logic [N-1:0]     mask_hi;
  logic [N:0]       sum_nxt;
  logic [N:0]       exact_nxt;
  logic             err_nxt;

  assign ke_in = KL'(eff_depth(int'(k), mode_exact, P_MAX));

  approx_lower_unit #(.N(N), .P_MAX(P_MAX)) u_lower (
    .x     (x),
    .y     (y),
    .ke    (ke_in),
    .lo    (lo_in),
    .carry (carry_in)
  );

  // Handshake: S2 frees when empty or draining; S1 frees when empty or moving into S2.
  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_vld || s2_load;
  assign in_ready = s1_load;

  // S2 input logic: exact ripple add of the upper part with the lower carry, plus error check.
  always_comb begin
    mask_hi   = {N{1'b1}} << s1_ke;
    sum_nxt   = ({1'b0, s1_x & mask_hi} + {1'b0, s1_y & mask_hi}
                 + ({{N{1'b0}}, s1_carry} << s1_ke)) | (N+1)'(s1_lo);
    exact_nxt = {1'b0, s1_x} + {1'b0, s1_y};
    err_nxt   = (sum_nxt != exact_nxt);
  end

  // S1 register: captures the lower result and the operands of an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_ke    <= '0;
      s1_lo    <= '0;
      s1_carry <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else if (s1_load) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_ke    <= ke_in;
        s1_lo    <= lo_in;
        s1_carry <= carry_in;
        s1_x     <= x;
        s1_y     <= y;
      end
    end
  end

  // S2 output register: holds sum/err_flag steady until the consumer takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      err_flag  <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        sum      <= sum_nxt;
        err_flag <= err_nxt;
      end
    end
  end

  // Saturating count of erroring transfers; clear takes priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_count) begin
      err_count <= '0;
    end else if (out_valid && out_ready && err_flag && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_approx_adder_pipe.sv
module tb_approx_adder_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic [3:0]  k;
  logic        mode_exact;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] sum;
  logic        err_flag;
  logic [15:0] err_count;
  logic        clr_count;

  int checks   = 0;
  int failures = 0;

  logic [17:0] exp_q[$];
  logic [15:0] cnt_m     = 16'd0;
  logic        prev_hold = 1'b0;
  logic [16:0] hold_sum;
  logic        hold_err;
  logic        last_acc  = 1'b0;

  approx_adder_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x          (x),
    .y          (y),
    .k          (k),
    .mode_exact (mode_exact),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .err_flag   (err_flag),
    .err_count  (err_count),
    .clr_count  (clr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: {err, sum} from the arithmetic definition of the approximate add.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input int kk, input logic me);
    int ke;
    logic [16:0] s, lo, c, ex;
    ke = me ? 0 : ((kk > 8) ? 8 : kk);
    ex = {1'b0, a} + {1'b0, b};
    if (ke == 0) begin
      s = ex;
    end else begin
      lo = '0;
      for (int i = 0; i < ke - 1; i++) lo[i] = a[i] | b[i];
      lo[ke-1] = (a[ke-1] & b[ke-1]) ? 1'b0 : (a[ke-1] | b[ke-1]);
      c = {16'd0, a[ke-1] & b[ke-1]};
      s = ((({1'b0, a} >> ke) + ({1'b0, b} >> ke) + c) << ke) | lo;
    end
    return {(s != ex), s};
  endfunction

  // Compare process: scoreboard, output stability, and err_count model every cycle.
  always @(negedge clk) begin
    logic [17:0] e;
    logic        xfer_err;
    if (!rst_n) begin
      exp_q.delete();
      cnt_m     = 16'd0;
      prev_hold = 1'b0;
      last_acc  = 1'b0;
    end else begin
      chk("err_count", {16'd0, err_count}, {16'd0, cnt_m});
      if (prev_hold) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data", {14'd0, err_flag, sum}, {14'd0, hold_err, hold_sum});
      end
      xfer_err = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", {15'd0, sum}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sum", {15'd0, sum}, {15'd0, e[16:0]});
          chk("err_flag", {31'd0, err_flag}, {31'd0, e[17]});
          xfer_err = e[17];
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(x, y, int'(k), mode_exact));
      if (clr_count) cnt_m = 16'd0;
      else if (xfer_err && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
      prev_hold = out_valid && !out_ready;
      hold_sum  = sum;
      hold_err  = err_flag;
      last_acc  = in_valid && in_ready;
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] kk,
                      input logic me);
    int n = 0;
    in_valid = 1'b1; x = a; y = b; k = kk; mode_exact = me;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, cyc, n;
    logic [15:0] beats_x [3];
    rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; k = '0; mode_exact = 1'b0;
    out_ready = 1'b1; clr_count = 1'b0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {15'd0, sum}, 32'd0);
    chk("rst_err_flag", {31'd0, err_flag}, 32'd0);
    chk("rst_err_count", {16'd0, err_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #2; rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Hand-computed values pin the model.
    chk("pin_ff_01_k8", {14'd0, model(16'h00FF, 16'h0001, 8, 1'b0)}, {14'd0, 1'b1, 17'h000FF});
    chk("pin_80_80_k8", {14'd0, model(16'h0080, 16'h0080, 8, 1'b0)}, {14'd0, 1'b0, 17'h00100});
    chk("pin_exact", {14'd0, model(16'hFFFF, 16'h0001, 5, 1'b1)}, {14'd0, 1'b0, 17'h10000});
    chk("pin_k12", {14'd0, model(16'hFFFF, 16'h0001, 12, 1'b0)}, {14'd0, 1'b1, 17'h0FFFF});

    // Directed beats through the DUT.
    send(16'h00FF, 16'h0001, 4'd8, 1'b0);
    idle(4);
    chk("count_0_to_1", {16'd0, err_count}, 32'd1);
    send(16'h0080, 16'h0080, 4'd8, 1'b0);
    send(16'hFFFF, 16'h0001, 4'd5, 1'b1);
    send(16'hFFFF, 16'h0001, 4'd12, 1'b0);
    idle(4);

    // Stall: three beats offered over five cycles with the output blocked.
    beats_x[0] = 16'h1234; beats_x[1] = 16'h0F0F; beats_x[2] = 16'hABCD;
    out_ready = 1'b0; acc = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; x = beats_x[acc]; y = 16'h00F7; k = 4'd6; mode_exact = 1'b0;
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    chk("stall_accepted", acc, 32'd2);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    n = 0;
    while (acc < 3 && n < 20) begin
      x = beats_x[acc];
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
      n++;
    end
    chk("stall_third", acc, 32'd3);
    in_valid = 1'b0;
    idle(4);

    // Randomized traffic with random backpressure and occasional clears.
    for (int c = 0; c < 3000; c++) begin
      if (!in_valid || last_acc) begin
        in_valid   = ($urandom_range(0, 3) != 0);
        x          = 16'($urandom);
        y          = 16'($urandom);
        k          = 4'($urandom_range(0, 15));
        mode_exact = ($urandom_range(0, 5) == 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      clr_count = ($urandom_range(0, 63) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; clr_count = 1'b0; out_ready = 1'b1;
    idle(5);

    // Saturation at full throughput.
    in_valid = 1'b1; x = 16'h00FF; y = 16'h0001; k = 4'd8; mode_exact = 1'b0;
    acc = 0; cyc = 0;
    while (acc < 65537 && cyc < 70000) begin
      @(negedge clk);
      if (in_ready) acc++;
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("throughput", cyc, 32'd65537);
    idle(5);
    chk("saturated", {16'd0, err_count}, 32'h0000FFFF);

    // Clear coincident with an erroring transfer.
    out_ready = 1'b0;
    send(16'h00FF, 16'h0001, 4'd8, 1'b0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("clr_wait", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    clr_count = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    chk("clr_wins", {16'd0, err_count}, 32'd0);

    // Reset with both stages full.
    send(16'h00FF, 16'h0001, 4'd8, 1'b0);
    idle(4);
    out_ready = 1'b0;
    send(16'h00FF, 16'h0001, 4'd8, 1'b0);
    send(16'h0F00, 16'h00FF, 4'd3, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_err_count", {16'd0, err_count}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("no_stale", {31'd0, out_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
